// File: rtl/display_scan_ctrl.sv
// Four-digit BCD scanner for a shared deco7seg decoder and common-segment display.
// Each digit slot is a short all-dark guard followed by the lit phase.
module display_scan_ctrl #(
    parameter int DIV   = 50000,
    parameter int GUARD = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        blank_lz,
    output logic [3:0]  bcd_out,
    output logic [3:0]  an,
    output logic [1:0]  dig_idx,
    output logic        frame_tick,
    output logic        err
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GUARD = 2'd1;
    localparam logic [1:0] S_SHOW  = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_dig;
    logic [15:0]   r_disp;
    logic [15:0]   r_pend;
    logic          r_pend_vld;
    logic          r_err;
    logic [3:0]    r_an;
    logic [3:0]    r_bcd;
    logic          r_frame;

    logic [1:0]    w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    w_dig_nxt;
    logic          w_wrap;
    logic          w_disp_wr;
    logic [15:0]   w_disp_src;
    logic [15:0]   w_disp_nxt;
    logic [3:0]    w_digit;
    logic          w_dark;

    function automatic logic f_has_bad(input logic [15:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 4; i++)
            if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    // A digit is dark if it is not BCD, or it is a leading zero when blanking is on.
    function automatic logic f_dark(input logic [15:0] v, input logic [1:0] k, input logic blz);
        logic [3:0] d;
        logic       z;
        d = v[{k, 2'b00} +: 4];
        case (k)
            2'd1:    z = (v[15:4]  == 12'd0);
            2'd2:    z = (v[15:8]  == 8'd0);
            2'd3:    z = (v[15:12] == 4'd0);
            default: z = 1'b0;
        endcase
        return (d > 4'd9) || (blz && z);
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dig_nxt   = r_dig;
        w_wrap      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_dig_nxt = '0;
                if (en) w_state_nxt = S_GUARD;
            end
            S_GUARD: begin
                if (!en) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_dig_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == GUARD_LAST) w_state_nxt = S_SHOW;
                end
            end
            S_SHOW: begin
                if (!en) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_dig_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_GUARD;
                    w_cnt_nxt   = '0;
                    w_dig_nxt   = r_dig + 2'd1;
                    w_wrap      = (r_dig == 2'd3);
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_dig_nxt   = '0;
            end
        endcase
    end

    // Idle loads go straight to the display; while scanning, pend is applied only at frame wrap.
    assign w_disp_wr  = ((r_state == S_IDLE) && load) || (w_wrap && r_pend_vld);
    assign w_disp_src = (r_state == S_IDLE) ? value : r_pend;
    assign w_disp_nxt = w_disp_wr ? w_disp_src : r_disp;
    assign w_digit    = w_disp_nxt[{w_dig_nxt, 2'b00} +: 4];
    assign w_dark     = f_dark(w_disp_nxt, w_dig_nxt, blank_lz);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_dig      <= '0;
            r_disp     <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_err      <= 1'b0;
            r_an       <= 4'b1111;
            r_bcd      <= '0;
            r_frame    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dig   <= w_dig_nxt;
            r_disp  <= w_disp_nxt;
            if (w_disp_wr) r_err <= f_has_bad(w_disp_src);
            // A load coinciding with the wrap lands in pend after the old pend is applied.
            if ((r_state != S_IDLE) && load) begin
                r_pend     <= value;
                r_pend_vld <= 1'b1;
            end else if (w_wrap) begin
                r_pend_vld <= 1'b0;
            end
            r_an    <= ((w_state_nxt == S_SHOW) && !w_dark) ? ~(4'b0001 << w_dig_nxt) : 4'b1111;
            r_bcd   <= w_digit;
            r_frame <= (w_state_nxt == S_SHOW) && (w_dig_nxt == 2'd3) && (w_cnt_nxt == CNT_LAST);
        end
    end

    assign bcd_out    = r_bcd;
    assign an         = r_an;
    assign dig_idx    = r_dig;
    assign frame_tick = r_frame;
    assign err        = r_err;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: slot-position model checked every cycle plus directed literal checks.
module tb_display_scan_ctrl;
    localparam int DIV   = 8;
    localparam int GUARD = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic        blank_lz = 1'b0;
    logic [3:0]  bcd_out;
    logic [3:0]  an;
    logic [1:0]  dig_idx;
    logic        frame_tick;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    display_scan_ctrl #(.DIV(DIV), .GUARD(GUARD)) dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .value(value),
        .blank_lz(blank_lz), .bcd_out(bcd_out), .an(an), .dig_idx(dig_idx),
        .frame_tick(frame_tick), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: a running flag and a position t within the 4-slot frame.
    bit          m_run = 0;
    int          m_t = 0;
    logic [15:0] m_disp = 0, m_pend = 0;
    bit          m_pv = 0, m_err = 0;
    logic [3:0]  e_an = 4'hF, e_bcd = 4'h0;
    logic [1:0]  e_dig = 2'd0;
    bit          e_ft = 0;

    function automatic bit m_bad(input logic [15:0] v);
        for (int i = 0; i < 4; i++)
            if (((v >> (4 * i)) & 16'hF) > 16'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_dark(input logic [15:0] v, input int k, input bit blz);
        logic [15:0] digit, above;
        digit = (v >> (4 * k)) & 16'hF;
        above = v >> (4 * k);
        return (digit > 16'd9) || (blz && k > 0 && above == 16'h0);
    endfunction

    task automatic model_step();
        int d;
        if (reset) begin
            m_run = 0; m_t = 0; m_disp = 0; m_pend = 0; m_pv = 0; m_err = 0;
        end else if (!m_run) begin
            if (load) begin m_disp = value; m_err = m_bad(value); end
            if (en) begin m_run = 1; m_t = 0; end
        end else begin
            if (!en) begin
                m_run = 0; m_t = 0;
            end else if (m_t == FRAME - 1) begin
                m_t = 0;
                if (m_pv) begin m_disp = m_pend; m_err = m_bad(m_pend); m_pv = 0; end
            end else begin
                m_t = m_t + 1;
            end
            if (load) begin m_pend = value; m_pv = 1; end
        end
        d     = m_run ? (m_t / DIV) % 4 : 0;
        e_dig = 2'(d);
        e_bcd = 4'((m_disp >> (4 * d)) & 16'hF);
        e_an  = (m_run && (m_t % DIV) >= GUARD && !m_dark(m_disp, d, blank_lz)) ? ~(4'b0001 << d) : 4'hF;
        e_ft  = m_run && (m_t == FRAME - 1);
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("model_an", {12'h0, an}, {12'h0, e_an});
        chk("model_dig_idx", {14'h0, dig_idx}, {14'h0, e_dig});
        chk("model_frame_tick", {15'h0, frame_tick}, {15'h0, e_ft});
        chk("model_err", {15'h0, err}, {15'h0, m_err});
        if (m_run) chk("model_bcd_out", {12'h0, bcd_out}, {12'h0, e_bcd});
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; value = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_frame();
        bit seen;
        seen = 0;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            @(negedge clk);
            if (frame_tick) seen = 1;
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_frame_timeout at %0t: got no frame_tick expected one within %0d cycles", $time, 2 * FRAME);
        end
    endtask

    task automatic lit(input string name, input logic [3:0] a, input logic [3:0] b);
        chk({name, "_an"}, {12'h0, an}, {12'h0, a});
        chk({name, "_bcd"}, {12'h0, bcd_out}, {12'h0, b});
    endtask

    initial begin
        tick(2);
        chk("rst_an", {12'h0, an}, 16'h000F);
        chk("rst_bcd", {12'h0, bcd_out}, 16'h0);
        chk("rst_dig", {14'h0, dig_idx}, 16'h0);
        chk("rst_ft", {15'h0, frame_tick}, 16'h0);
        chk("rst_err", {15'h0, err}, 16'h0);
        reset = 1'b0;
        tick(1);

        // Test 1: idle load of 1234 then scan.
        load = 1'b1; value = 16'h1234; en = 1'b1;
        tick(1); load = 1'b0;
        chk("t1_guard_an", {12'h0, an}, 16'h000F);
        tick(2);  lit("t1_d0", 4'b1110, 4'h4);
        tick(8);  lit("t1_d1", 4'b1101, 4'h3);
        tick(8);  lit("t1_d2", 4'b1011, 4'h2);
        tick(8);  lit("t1_d3", 4'b0111, 4'h1);
        tick(5);  chk("t1_frame", {15'h0, frame_tick}, 16'h1);

        // Test 2: mid-frame load does not disturb the current frame.
        tick(11);
        do_load(16'h5678);
        lit("t2_old_d1", 4'b1101, 4'h3);
        tick(8);  lit("t2_old_d2", 4'b1011, 4'h2);
        wait_frame();
        lit("t2_old_d3", 4'b0111, 4'h1);
        tick(3);  lit("t2_new_d0", 4'b1110, 4'h8);
        tick(8);  lit("t2_new_d1", 4'b1101, 4'h7);

        // Test 3: leading-zero blanking.
        blank_lz = 1'b1;
        do_load(16'h0050);
        wait_frame();
        tick(3);  lit("t3_d0", 4'b1110, 4'h0);
        tick(8);  lit("t3_d1", 4'b1101, 4'h5);
        tick(8);  lit("t3_d2", 4'b1111, 4'h0);
        tick(8);  lit("t3_d3", 4'b1111, 4'h0);
        do_load(16'h0000);
        wait_frame();
        tick(3);  lit("t3_z_d0", 4'b1110, 4'h0);
        tick(8);  lit("t3_z_d1", 4'b1111, 4'h0);

        // Test 4: invalid digit raises err and is suppressed.
        blank_lz = 1'b0;
        do_load(16'h12A4);
        wait_frame();
        tick(1);  chk("t4_err_set", {15'h0, err}, 16'h1);
        tick(10); lit("t4_d1", 4'b1111, 4'hA);
        tick(8);  lit("t4_d2", 4'b1011, 4'h2);
        do_load(16'h1111);
        wait_frame();
        chk("t4_err_hold", {15'h0, err}, 16'h1);
        tick(1);  chk("t4_err_clr", {15'h0, err}, 16'h0);

        // Test 5: disable during SHOW, then re-enable.
        tick(18);
        en = 1'b0;
        tick(1);
        chk("t5_off_an", {12'h0, an}, 16'h000F);
        chk("t5_off_dig", {14'h0, dig_idx}, 16'h0);
        tick(2);
        en = 1'b1;
        tick(1);  chk("t5_g0_an", {12'h0, an}, 16'h000F);
        tick(1);  chk("t5_g1_an", {12'h0, an}, 16'h000F);
        tick(1);  lit("t5_d0", 4'b1110, 4'h1);

        // Test 6: reset mid-scan with a pending value.
        tick(8);
        do_load(16'h9876);
        tick(8);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_an", {12'h0, an}, 16'h000F);
        chk("t6_rst_bcd", {12'h0, bcd_out}, 16'h0);
        chk("t6_rst_dig", {14'h0, dig_idx}, 16'h0);
        chk("t6_rst_err", {15'h0, err}, 16'h0);
        @(negedge clk);
        reset = 1'b0;
        tick(1);  chk("t6_g_an", {12'h0, an}, 16'h000F);
        tick(2);  lit("t6_d0", 4'b1110, 4'h0);
        wait_frame();
        tick(3);  lit("t6_next_d0", 4'b1110, 4'h0);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
